// File: rtl/tug_field.sv
// Tug-of-war playfield: key edge detection, one-hot light movement, serve blanking between rounds.
// Press pulses are combinational (same cycle as key edge); light moves on the following clock.
module tug_field #(
  parameter int NUM_LIGHTS   = 9,
  parameter int CENTER       = (NUM_LIGHTS - 1) / 2,
  parameter int SERVE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L_key,
  input  logic                  R_key,
  input  logic                  playAgain,
  input  logic                  matchOver,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  leftEdge,
  output logic                  rightEdge,
  output logic                  L_press,
  output logic                  R_press
);

  localparam int PW     = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int CW_RAW = $clog2(SERVE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [PW-1:0] POS_MAX  = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0] POS_CTR  = PW'(CENTER);
  localparam logic [CW-1:0] CNT_LAST = CW'((SERVE_CYCLES > 0) ? SERVE_CYCLES - 1 : 0);

  typedef enum logic {
    ST_PLAY  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic [CW-1:0] r_cnt;
  logic          r_lprev;
  logic          r_rprev;

  state_t        w_state_nxt;
  logic [PW-1:0] w_pos_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_play;
  logic          w_l_only;
  logic          w_r_only;
  logic          w_point;

  assign w_play   = (r_state == ST_PLAY);
  assign L_press  = L_key & ~r_lprev & w_play & ~matchOver;
  assign R_press  = R_key & ~r_rprev & w_play & ~matchOver;
  assign w_l_only = L_press & ~R_press;
  assign w_r_only = R_press & ~L_press;
  // A push off either end of the row, or a victory counter's playAgain, ends the round.
  assign w_point  = playAgain
                  | (w_l_only & (r_pos == POS_MAX))
                  | (w_r_only & (r_pos == '0));

  assign leds      = w_play ? (NUM_LIGHTS'(1) << r_pos) : '0;
  assign leftEdge  = w_play & (r_pos == POS_MAX);
  assign rightEdge = w_play & (r_pos == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_cnt_nxt   = r_cnt;
    if (!matchOver) begin
      case (r_state)
        ST_PLAY: begin
          if (w_point) begin
            if (SERVE_CYCLES > 0) begin
              w_state_nxt = ST_SERVE;
              w_cnt_nxt   = '0;
            end else begin
              w_pos_nxt = POS_CTR;
            end
          end else if (w_l_only) begin
            w_pos_nxt = r_pos + PW'(1);
          end else if (w_r_only) begin
            w_pos_nxt = r_pos - PW'(1);
          end
        end
        ST_SERVE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_PLAY;
            w_pos_nxt   = POS_CTR;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_PLAY;
          w_pos_nxt   = POS_CTR;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Key history starts at 1 so a key held through reset never registers as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PLAY;
      r_pos   <= POS_CTR;
      r_cnt   <= '0;
      r_lprev <= 1'b1;
      r_rprev <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lprev <= L_key;
      r_rprev <= R_key;
    end
  end

endmodule

// File: tb/tb_tug_field.sv
// Bench for tug_field: vector table plus hand-written round sequences, checked through an expectation queue.
module tb_tug_field;

  logic       clk = 1'b0;
  logic       reset;
  logic       L_key, R_key, playAgain, matchOver;
  logic [8:0] leds;
  logic       leftEdge, rightEdge, L_press, R_press;

  int checks = 0;
  int errors = 0;

  tug_field #(.NUM_LIGHTS(9), .CENTER(4), .SERVE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .L_key     (L_key),
    .R_key     (R_key),
    .playAgain (playAgain),
    .matchOver (matchOver),
    .leds      (leds),
    .leftEdge  (leftEdge),
    .rightEdge (rightEdge),
    .L_press   (L_press),
    .R_press   (R_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       chk;
    logic       rst;
    logic       l;
    logic       r;
    logic       p;
    logic       m;
    logic [8:0] e_leds;
    logic       e_le;
    logic       e_re;
    logic       e_lp;
    logic       e_rp;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] val;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(string name, logic chk, logic rst, logic l, logic r, logic p,
                              logic m, logic [8:0] el, logic le, logic re, logic lp, logic rp);
    vec_t v;
    v.name = name; v.chk = chk; v.rst = rst; v.l = l; v.r = r; v.p = p; v.m = m;
    v.e_leds = el; v.e_le = le; v.e_re = re; v.e_lp = lp; v.e_rp = rp;
    return v;
  endfunction

  // Inputs are applied on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got_e;
    logic [12:0] got;
    @(negedge clk);
    reset = v.rst; L_key = v.l; R_key = v.r; playAgain = v.p; matchOver = v.m;
    if (v.chk) begin
      e.name = v.name;
      e.val  = {v.e_leds, v.e_le, v.e_re, v.e_lp, v.e_rp};
      exp_q.push_back(e);
    end
    #1;
    if (v.chk && exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      got   = {leds, leftEdge, rightEdge, L_press, R_press};
      checks++;
      if (got !== got_e.val) begin
        errors++;
        $display("FAIL %s: got leds=%b le=%b re=%b lp=%b rp=%b, want leds=%b le=%b re=%b lp=%b rp=%b",
                 got_e.name, got[12:4], got[3], got[2], got[1], got[0],
                 got_e.val[12:4], got_e.val[3], got_e.val[2], got_e.val[1], got_e.val[0]);
      end
    end
  endtask

  task automatic do_reset();
    step(mk("rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("rst_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    reset = 1'b1; L_key = 1'b0; R_key = 1'b0; playAgain = 1'b0; matchOver = 1'b0;

    // Key held through reset, then one clean press.
    tbl.push_back(mk("hold_rst",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("hold_1",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("hold_2",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("hold_3",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("release",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("l_press",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("l_moved",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h020, 1'b0, 1'b0, 1'b0, 1'b0));
    // Simultaneous presses.
    tbl.push_back(mk("rst",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("idle",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("both",       1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk("both_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    // Left win from centre.
    tbl.push_back(mk("lw_p1",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("lw_r1",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h020, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_p2",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h020, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("lw_r2",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_p3",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h040, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("lw_r3",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h080, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_p4",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h080, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("lw_edge",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_p5",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("lw_serve0",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_serve1",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_serve2",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_serve3",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("lw_recentre",1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    // Freeze at position 6.
    tbl.push_back(mk("fz_p1",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("fz_r1",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h020, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_p2",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h020, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("fz_pos6",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_both1",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_idle1",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_both2",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_left",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_idle2",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_thaw",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk("fz_lpress",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h040, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("fz_pos7",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h080, 1'b0, 1'b0, 1'b0, 1'b0));

    foreach (tbl[i]) step(tbl[i]);

    // R held for 10 cycles from centre: one pulse, one move.
    do_reset();
    for (int i = 0; i < 10; i++)
      step(mk("r_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              (i == 0) ? 9'h010 : 9'h008, 1'b0, 1'b0, 1'b0, (i == 0)));
    step(mk("r_hold_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h008, 1'b0, 1'b0, 1'b0, 1'b0));

    // Right win: walk to position 0, push off the end, serve, recentre.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(mk("rw_press", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              9'h010 >> k, 1'b0, 1'b0, 1'b0, 1'b1));
      step(mk("rw_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              9'h010 >> (k + 1), 1'b0, (k == 3), 1'b0, 1'b0));
    end
    step(mk("rw_point", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h001, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++)
      step(mk("rw_serve", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("rw_recentre", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));

    // playAgain point, reset in 2nd serve cycle, then a full serve after the next point.
    do_reset();
    step(mk("pa_point",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("pa_serve0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("pa_rst_srv", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("pa_after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("pa_point2",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++)
      step(mk("pa_full_serve", 1'b1, 1'b0, 1'b0, 1'b0, (k == 1), 1'b0,
              9'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk("pa_recentre", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b0, 1'b0, 1'b0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
